// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Central sequencing FSM for the multi-cycle RV32 core. Each instruction walks
// FETCH -> DECODE -> EXEC -> [MUL_WAIT | MEM] -> [WB] -> FETCH. The block drives
// the memory handshake, IR/PC/register-file write enables, datapath mux selects
// and the multiplier launch pulse. It parks in HALT on the null instruction and
// in TRAP on an illegal opcode or a handshake that never completes.
//
// Ports
//   clk           core clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   op_type[4:0]  decoder instruction class (I_* encodings below)
//   branch_taken  ALU compare result, used only in EXEC for branches
//   mem_ack       memory completion strobe, ignored unless mem_req is high
//   mul_done      multiplier completion strobe, used only in MUL_WAIT
//   mem_req       memory request, held until acknowledged
//   mem_we        store strobe qualifying mem_req
//   addr_sel      memory address: 0 = PC, 1 = rs1 + offset
//   ir_we         instruction-register load
//   pc_we         PC update
//   pc_sel        next PC: 0 = PC+4, 1 = PC+offset
//   rf_we         register-file write
//   wb_sel[1:0]   writeback source: 0 ALU, 1 memory, 2 PC+4, 3 immediate
//   mul_start     one-cycle multiplier launch
//   state_o[2:0]  current state (debug)
//   halted        sticky, null instruction seen
//   illegal       sticky, illegal opcode seen
//   timeout       sticky, handshake timeout
//   instret       retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       op_type,
    input  logic             branch_taken,
    input  logic             mem_ack,
    input  logic             mul_done,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             mul_start,
    output logic [2:0]       state_o,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instret
);

    // Instruction class encodings shared with the decoder.
    localparam logic [4:0] I_NULL  = 5'd0;
    localparam logic [4:0] I_ADD   = 5'd1;
    localparam logic [4:0] I_SUB   = 5'd2;
    localparam logic [4:0] I_XOR   = 5'd3;
    localparam logic [4:0] I_OR    = 5'd4;
    localparam logic [4:0] I_AND   = 5'd5;
    localparam logic [4:0] I_ADDI  = 5'd6;
    localparam logic [4:0] I_LUI   = 5'd7;
    localparam logic [4:0] I_AUIPC = 5'd8;
    localparam logic [4:0] I_JAL   = 5'd9;
    localparam logic [4:0] I_MUL   = 5'd10;
    localparam logic [4:0] I_MULH  = 5'd11;
    localparam logic [4:0] I_LW    = 5'd12;
    localparam logic [4:0] I_SW    = 5'd13;
    localparam logic [4:0] I_BEQ   = 5'd14;
    localparam logic [4:0] I_BNE   = 5'd15;
    localparam logic [4:0] I_BLT   = 5'd16;
    localparam logic [4:0] I_BGE   = 5'd17;
    localparam logic [4:0] I_ERR   = 5'd31;

    // The wait counter only has to reach TIMEOUT-1.
    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MUL_WAIT = 3'd3,
        S_MEM      = 3'd4,
        S_WB       = 3'd5,
        S_HALT     = 3'd6,
        S_TRAP     = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    logic               mem_req_s, mem_we_s, addr_sel_s, ir_we_s, pc_we_s;
    logic               pc_sel_s, rf_we_s, mul_start_s, retire_s, wait_hit_s;
    logic [1:0]         wb_sel_s;

    // Every opcode the datapath knows how to execute (I_NULL handled separately).
    function automatic logic is_exec_op(input logic [4:0] op);
        logic ok;
        case (op)
            I_ADD, I_SUB, I_XOR, I_OR, I_AND, I_ADDI, I_LUI, I_AUIPC, I_JAL,
            I_MUL, I_MULH, I_LW, I_SW, I_BEQ, I_BNE, I_BLT, I_BGE: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Next-state, flag, counter and control-output decode.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        addr_sel_s  = 1'b0;
        ir_we_s     = 1'b0;
        pc_we_s     = 1'b0;
        pc_sel_s    = 1'b0;
        rf_we_s     = 1'b0;
        wb_sel_s    = 2'd0;
        mul_start_s = 1'b0;
        retire_s    = 1'b0;
        wait_hit_s  = (wait_q == WAIT_LAST);

        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ack) begin
                    ir_we_s = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_hit_s) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                op_d = op_type;
                if (op_type == I_NULL) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (is_exec_op(op_type)) begin
                    state_d = S_EXEC;
                end else begin
                    // I_ERR lands here along with every unlisted encoding.
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    I_MUL, I_MULH: begin
                        mul_start_s = 1'b1;
                        state_d     = S_MUL_WAIT;
                    end
                    I_LW, I_SW: begin
                        state_d = S_MEM;
                    end
                    I_BEQ, I_BNE, I_BLT, I_BGE: begin
                        pc_we_s  = 1'b1;
                        pc_sel_s = branch_taken;
                        retire_s = 1'b1;
                        state_d  = S_FETCH;
                    end
                    I_ADD, I_SUB, I_XOR, I_OR, I_AND, I_ADDI, I_LUI, I_AUIPC,
                    I_JAL: begin
                        state_d = S_WB;
                    end
                    default: begin
                        // op_q was already screened in DECODE; treat corruption as illegal.
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MUL_WAIT: begin
                if (mul_done) begin
                    state_d = S_WB;
                end else if (wait_hit_s) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_MUL_WAIT;
                end
            end
            S_MEM: begin
                mem_req_s  = 1'b1;
                addr_sel_s = 1'b1;
                mem_we_s   = (op_q == I_SW);
                if (mem_ack) begin
                    if (op_q == I_SW) begin
                        // Stores have nothing to write back and retire here.
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_hit_s) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                rf_we_s  = 1'b1;
                pc_we_s  = 1'b1;
                pc_sel_s = (op_q == I_JAL);
                retire_s = 1'b1;
                state_d  = S_FETCH;
                case (op_q)
                    I_LW:    wb_sel_s = 2'd1;
                    I_JAL:   wb_sel_s = 2'd2;
                    I_LUI:   wb_sel_s = 2'd3;
                    default: wb_sel_s = 2'd0;
                endcase
            end
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // Counter restarts on any state change; while parked in a wait state
        // the awaited strobe is necessarily low, so it simply counts up.
        if (state_d != state_q) begin
            wait_d = {WAIT_W{1'b0}};
        end else if ((state_q == S_FETCH) || (state_q == S_MEM) ||
                     (state_q == S_MUL_WAIT)) begin
            wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_d = {WAIT_W{1'b0}};
        end

        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire_s};
    end

    // State, latched opcode, wait counter, sticky flags and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 5'd0;
            wait_q    <= {WAIT_W{1'b0}};
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            instret_q <= instret_d;
        end
    end

    // Reset masks every output, so an aborted instruction never fires an enable.
    assign mem_req   = mem_req_s   & ~rst;
    assign mem_we    = mem_we_s    & ~rst;
    assign addr_sel  = addr_sel_s  & ~rst;
    assign ir_we     = ir_we_s     & ~rst;
    assign pc_we     = pc_we_s     & ~rst;
    assign pc_sel    = pc_sel_s    & ~rst;
    assign rf_we     = rf_we_s     & ~rst;
    assign wb_sel    = rst ? 2'd0 : wb_sel_s;
    assign mul_start = mul_start_s & ~rst;
    assign state_o   = rst ? 3'd0 : state_q;
    assign halted    = halted_q    & ~rst;
    assign illegal   = illegal_q   & ~rst;
    assign timeout   = timeout_q   & ~rst;
    assign instret   = rst ? {CNT_W{1'b0}} : instret_q;

endmodule
